// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one rq/ack bus server among NUM_CLIENTS clients.
// One transaction in flight; a server that never answers is aborted after TIMEOUT_CYCLES.
module bus_arbiter #(
   parameter int NUM_CLIENTS    = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int IDX_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            cl_rq,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
   input  logic [NUM_CLIENTS-1:0]            cl_wr_ni,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW,
   output logic [NUM_CLIENTS-1:0]            cl_ack,
   output logic [DATA_WIDTH-1:0]             cl_dataR,
   output logic                              srv_rq,
   input  logic                              srv_ack,
   output logic [ADDR_WIDTH-1:0]             srv_address,
   output logic                              srv_wr_ni,
   output logic [DATA_WIDTH-1:0]             srv_dataW,
   input  logic [DATA_WIDTH-1:0]             srv_dataR,
   output logic                              grant_valid,
   output logic [IDX_W-1:0]                  grant_idx,
   output logic                              timeout_err,
   output logic [1:0]                        o_dbg_state
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_grant_idx;
   logic [CNT_W-1:0]        r_cnt;
   logic [NUM_CLIENTS-1:0]  r_cl_ack;
   logic [DATA_WIDTH-1:0]   r_cl_dataR;
   logic                    r_timeout_err;
   logic                    r_srv_rq;
   logic                    r_grant_valid;

   logic                    w_found;
   logic [IDX_W-1:0]        w_winner;
   logic [IDX_W-1:0]        w_cand;
   logic [NUM_CLIENTS-1:0]  w_grant_onehot;
   logic                    w_busy;

   // Search upward from the client after the last grant, wrapping, so the
   // most recently served client has the lowest priority next time.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_grant_idx;
      w_cand   = '0;
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
         if (int'(r_grant_idx) + k >= NUM_CLIENTS)
            w_cand = IDX_W'(int'(r_grant_idx) + k - NUM_CLIENTS);
         else
            w_cand = IDX_W'(int'(r_grant_idx) + k);
         if (!w_found && cl_rq[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   assign w_grant_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << r_grant_idx;
   assign w_busy         = (r_state == S_BUSY);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_grant_idx   <= IDX_W'(NUM_CLIENTS - 1);
         r_cnt         <= '0;
         r_cl_ack      <= '0;
         r_cl_dataR    <= '0;
         r_timeout_err <= 1'b0;
         r_srv_rq      <= 1'b0;
         r_grant_valid <= 1'b0;
      end else begin
         r_cl_ack      <= '0;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant_idx   <= w_winner;
                  r_srv_rq      <= 1'b1;
                  r_grant_valid <= 1'b1;
                  r_state       <= S_BUSY;
               end
            end
            S_BUSY: begin
               // A completion on the limit cycle still wins over the abort.
               if (srv_ack) begin
                  r_cl_dataR <= srv_dataR;
                  r_cnt      <= '0;
                  r_cl_ack   <= w_grant_onehot;
                  r_srv_rq   <= 1'b0;
                  r_state    <= S_ACK;
               end else if (r_cnt == CNT_LIMIT) begin
                  r_cl_dataR    <= '0;
                  r_timeout_err <= 1'b1;
                  r_cnt         <= '0;
                  r_cl_ack      <= w_grant_onehot;
                  r_srv_rq      <= 1'b0;
                  r_state       <= S_ACK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_ACK: begin
               r_grant_valid <= 1'b0;
               r_state       <= S_RELEASE;
            end
            S_RELEASE: begin
               // Hold off re-arbitration until the served client drops its stale rq.
               if (!cl_rq[r_grant_idx])
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign srv_address = w_busy ? cl_address[r_grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign srv_dataW   = w_busy ? cl_dataW[r_grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign srv_wr_ni   = w_busy ? cl_wr_ni[r_grant_idx] : 1'b0;

   assign cl_ack      = r_cl_ack;
   assign cl_dataR    = r_cl_dataR;
   assign srv_rq      = r_srv_rq;
   assign grant_valid = r_grant_valid;
   assign grant_idx   = r_grant_idx;
   assign timeout_err = r_timeout_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a behavioural server and clients, a completion
// scoreboard fed at stimulus time, and immediate assertions at each check point.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int IW = 2;
   localparam int EW = 1 + IW + DW;

   logic            clk;
   logic            reset;
   logic [N-1:0]    cl_rq;
   logic [N*AW-1:0] cl_address;
   logic [N-1:0]    cl_wr_ni;
   logic [N*DW-1:0] cl_dataW;
   logic [N-1:0]    cl_ack;
   logic [DW-1:0]   cl_dataR;
   logic            srv_rq;
   logic            srv_ack;
   logic [AW-1:0]   srv_address;
   logic            srv_wr_ni;
   logic [DW-1:0]   srv_dataW;
   logic [DW-1:0]   srv_dataR;
   logic            grant_valid;
   logic [IW-1:0]   grant_idx;
   logic            timeout_err;
   logic [1:0]      o_dbg_state;

   bus_arbiter #(
      .NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .cl_rq(cl_rq), .cl_address(cl_address),
      .cl_wr_ni(cl_wr_ni), .cl_dataW(cl_dataW), .cl_ack(cl_ack), .cl_dataR(cl_dataR),
      .srv_rq(srv_rq), .srv_ack(srv_ack), .srv_address(srv_address),
      .srv_wr_ni(srv_wr_ni), .srv_dataW(srv_dataW), .srv_dataR(srv_dataR),
      .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_err(timeout_err),
      .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int            n_assert = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic [AW-1:0] tb_addr[N];
   logic [DW-1:0] tb_dw[N];
   logic          tb_wr[N];
   int            req_cnt[N];
   int            cool[N];
   bit            auto_client = 1'b0;
   int            srv_wait    = 0;
   int            busy_cnt    = 0;
   int            n_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic to, input int idx, input logic [DW-1:0] d);
      logic [IW-1:0] i;
      i = IW'(idx);
      return {to, i, d};
   endfunction

   function automatic logic [DW-1:0] srv_fn(input logic [AW-1:0] a, input logic [DW-1:0] d);
      return {a, a} ^ d;
   endfunction

   task automatic set_client(input int i, input logic [AW-1:0] a, input logic wr,
                             input logic [DW-1:0] d);
      tb_addr[i] = a;
      tb_wr[i]   = wr;
      tb_dw[i]   = d;
      cl_address[i*AW +: AW] = a;
      cl_wr_ni[i]            = wr;
      cl_dataW[i*DW +: DW]   = d;
   endtask

   // Client model: drop rq on seeing ack, stay low one more cycle, re-raise while work remains.
   task automatic drive_clients();
      for (int i = 0; i < N; i++) begin
         if (cl_ack[i]) begin
            cl_rq[i] = 1'b0;
            req_cnt[i]--;
            cool[i] = 1;
         end else if (cool[i] > 0) begin
            cool[i]--;
         end else begin
            cl_rq[i] = (req_cnt[i] > 0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_client) drive_clients();
   endtask

   task automatic clear_clients();
      for (int i = 0; i < N; i++) begin
         req_cnt[i] = 0;
         cool[i]    = 0;
      end
      cl_rq = '0;
   endtask

   task automatic wait_srv_rq(input int max_cyc);
      int n;
      n = 0;
      while (srv_rq !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      chk("wait_srv_rq_bound", {31'd0, srv_rq}, 32'd1);
   endtask

   task automatic wait_ack(input int max_cyc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (cl_ack === '0 && n < max_cyc);
      chk("wait_ack_bound", {31'd0, (cl_ack !== '0)}, 32'd1);
   endtask

   // Counts BUSY cycles from the first srv_rq-high sample up to the ack cycle.
   task automatic count_busy(output int n);
      n = 1;
      while (srv_rq === 1'b1 && n < 40) begin
         tick();
         if (srv_rq === 1'b1) n++;
      end
   endtask

   // ---------------- server model ----------------
   initial begin
      srv_ack   = 1'b0;
      srv_dataR = '0;
      forever begin
         @(negedge clk);
         if (srv_rq === 1'b1) begin
            srv_ack   = (srv_wait >= 0 && busy_cnt == srv_wait);
            srv_dataR = srv_fn(srv_address, srv_dataW);
            busy_cnt++;
         end else begin
            srv_ack   = 1'b0;
            srv_dataR = 8'hEE;
            busy_cnt  = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   initial begin
      logic [EW-1:0] obs, expv;
      logic [IW-1:0] idx;
      forever begin
         @(negedge clk);
         if (cl_ack !== '0) begin
            chk("ack_onehot", {31'd0, $onehot(cl_ack)}, 32'd1);
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_ack observed=%0h expected=none", cl_ack);
            end
            if (exp_q.size() != 0) begin
               idx = '0;
               for (int i = 0; i < N; i++) if (cl_ack[i]) idx = IW'(i);
               obs  = {timeout_err, idx, cl_dataR};
               expv = exp_q.pop_front();
               chk("sb_completion", 32'(obs), 32'(expv));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      reset = 1'b0;
      cl_rq = '0; cl_address = '0; cl_wr_ni = '0; cl_dataW = '0;
      clear_clients();
      for (int i = 0; i < N; i++) set_client(i, '0, 1'b0, '0);
      tick(); tick();

      // Reset state
      chk("rst_srv_rq",      {31'd0, srv_rq}, 32'd0);
      chk("rst_cl_ack",      32'(cl_ack), 32'd0);
      chk("rst_cl_dataR",    32'(cl_dataR), 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
      chk("rst_grant_idx",   32'(grant_idx), 32'd3);
      chk("rst_srv_address", 32'(srv_address), 32'd0);
      reset = 1'b1;
      tick();

      // Single read from client 2
      set_client(2, 4'h5, 1'b1, 8'hF0);
      exp_q.push_back(mk(1'b0, 2, 8'hA5));
      cl_rq = 4'b0100;
      tick();
      chk("rd_srv_rq",      {31'd0, srv_rq}, 32'd1);
      chk("rd_grant_idx",   32'(grant_idx), 32'd2);
      chk("rd_grant_valid", {31'd0, grant_valid}, 32'd1);
      chk("rd_srv_address", 32'(srv_address), 32'd5);
      chk("rd_srv_wr_ni",   {31'd0, srv_wr_ni}, 32'd1);
      chk("rd_srv_dataW",   32'(srv_dataW), 32'hF0);
      tick();
      chk("rd_cl_ack",      32'(cl_ack), 32'b0100);
      chk("rd_cl_dataR",    32'(cl_dataR), 32'hA5);
      chk("rd_srv_rq_low",  {31'd0, srv_rq}, 32'd0);
      chk("rd_addr_idle",   32'(srv_address), 32'd0);
      chk("rd_timeout_err", {31'd0, timeout_err}, 32'd0);
      cl_rq = '0;
      tick();
      chk("rd_ack_pulse",   32'(cl_ack), 32'd0);
      chk("rd_dataR_hold",  32'(cl_dataR), 32'hA5);
      chk("rd_release_gv",  {31'd0, grant_valid}, 32'd0);
      tick(); tick();

      // Contention between clients 0 and 3 right after reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      set_client(0, 4'h1, 1'b1, 8'h11);
      set_client(3, 4'h7, 1'b0, 8'hC3);
      auto_client = 1'b1;
      req_cnt[0] = 1; req_cnt[3] = 1;
      cl_rq = 4'b1001;
      exp_q.push_back(mk(1'b0, 0, srv_fn(4'h1, 8'h11)));
      exp_q.push_back(mk(1'b0, 3, srv_fn(4'h7, 8'hC3)));
      wait_srv_rq(10);
      chk("ct_first_grant", 32'(grant_idx), 32'd0);
      chk("ct_dataW_0",     32'(srv_dataW), 32'(tb_dw[0]));
      chk("ct_addr_0",      32'(srv_address), 32'(tb_addr[0]));
      wait_ack(40, n);
      wait_srv_rq(10);
      chk("ct_second_grant", 32'(grant_idx), 32'd3);
      chk("ct_dataW_3",      32'(srv_dataW), 32'(tb_dw[3]));
      chk("ct_wr_ni_3",      {31'd0, srv_wr_ni}, {31'd0, tb_wr[3]});
      wait_ack(40, n);
      tick(); tick(); tick();

      // Round-robin wrap with continuous requests and a zero-wait server
      set_client(0, 4'h3, 1'b1, 8'h12);
      set_client(1, 4'h9, 1'b1, 8'h34);
      set_client(2, 4'hC, 1'b1, 8'h56);
      set_client(3, 4'h6, 1'b1, 8'h78);
      clear_clients();
      req_cnt[0] = 2; req_cnt[1] = 2; req_cnt[2] = 1; req_cnt[3] = 1;
      cl_rq = 4'b1111;
      for (int t = 0; t < 6; t++) begin
         int c;
         c = t % N;
         exp_q.push_back(mk(1'b0, c, srv_fn(tb_addr[c], tb_dw[c])));
      end
      for (int t = 0; t < 6; t++) begin
         wait_ack(40, n);
         if (t > 0) chk("rr_period", n, 32'd4);
      end
      tick(); tick(); tick();

      // Server never answers: abort after 16 BUSY cycles
      srv_wait = -1;
      clear_clients();
      req_cnt[1] = 1;
      cl_rq = 4'b0010;
      exp_q.push_back(mk(1'b1, 1, 8'h00));
      wait_srv_rq(10);
      chk("to_grant_idx", 32'(grant_idx), 32'd1);
      count_busy(n);
      chk("to_busy_cycles", n, 32'd16);
      chk("to_timeout_err", {31'd0, timeout_err}, 32'd1);
      chk("to_cl_ack",      32'(cl_ack), 32'b0010);
      chk("to_cl_dataR",    32'(cl_dataR), 32'd0);
      tick();
      chk("to_err_pulse",   {31'd0, timeout_err}, 32'd0);
      chk("to_ack_pulse",   32'(cl_ack), 32'd0);
      tick(); tick();
      chk("to_back_idle",   {31'd0, grant_valid}, 32'd0);

      // Ack on the limit cycle counts as success
      srv_wait = 15;
      set_client(2, 4'hB, 1'b1, 8'h0F);
      req_cnt[2] = 1;
      cl_rq = 4'b0100;
      exp_q.push_back(mk(1'b0, 2, 8'hB4));
      wait_srv_rq(10);
      count_busy(n);
      chk("lim_busy_cycles", n, 32'd16);
      chk("lim_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("lim_cl_ack",      32'(cl_ack), 32'b0100);
      chk("lim_cl_dataR",    32'(cl_dataR), 32'hB4);
      tick(); tick(); tick();

      // Reset during the third cycle of a wait-stated transaction
      srv_wait = 10;
      req_cnt[2] = 1;
      cl_rq = 4'b0100;
      wait_srv_rq(10);
      tick(); tick();
      reset = 1'b0;
      clear_clients();
      tick();
      chk("mr_srv_rq",      {31'd0, srv_rq}, 32'd0);
      chk("mr_cl_ack",      32'(cl_ack), 32'd0);
      chk("mr_grant_idx",   32'(grant_idx), 32'd3);
      chk("mr_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("mr_grant_valid", {31'd0, grant_valid}, 32'd0);
      reset = 1'b1;
      srv_wait = 0;
      set_client(0, 4'h2, 1'b0, 8'h9A);
      set_client(1, 4'hE, 1'b1, 8'h01);
      req_cnt[0] = 1; req_cnt[1] = 1;
      cl_rq = 4'b0011;
      exp_q.push_back(mk(1'b0, 0, srv_fn(4'h2, 8'h9A)));
      exp_q.push_back(mk(1'b0, 1, srv_fn(4'hE, 8'h01)));
      wait_srv_rq(10);
      chk("mr_first_grant", 32'(grant_idx), 32'd0);
      wait_ack(40, n);
      wait_ack(40, n);
      tick(); tick(); tick();

      // Stale rq held two cycles past ack blocks re-arbitration
      auto_client = 1'b0;
      clear_clients();
      set_client(3, 4'h4, 1'b1, 8'h66);
      set_client(1, 4'hD, 1'b1, 8'h21);
      cl_rq = 4'b1010;
      exp_q.push_back(mk(1'b0, 3, srv_fn(4'h4, 8'h66)));
      exp_q.push_back(mk(1'b0, 1, srv_fn(4'hD, 8'h21)));
      wait_srv_rq(10);
      chk("st_grant_idx", 32'(grant_idx), 32'd3);
      wait_ack(40, n);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("st_no_regrant", {30'd0, srv_rq, grant_valid}, 32'd0);
      end
      cl_rq[3] = 1'b0;
      tick();
      chk("st_idle_after_drop", {31'd0, srv_rq}, 32'd0);
      tick();
      chk("st_rearb_rq",  {31'd0, srv_rq}, 32'd1);
      chk("st_rearb_idx", 32'(grant_idx), 32'd1);
      wait_ack(40, n);
      cl_rq = '0;
      tick(); tick(); tick();

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
